// File: rtl/systolic_tile_scheduler.sv
// rtl/systolic_tile_scheduler.sv - tiled GEMM sequencer for a 4x4 output-stationary MAC array
// Walks mi/ni/ki tile loops, feeds A/B tiles to the array and streams accumulated C tiles.

module systolic_tile_scheduler #(
  parameter int AW    = 8,
  parameter int BW    = 8,
  parameter int ACCW  = 32,
  parameter int TW    = 8,
  parameter int ADDRW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [TW-1:0]       cmd_m_tiles,
  input  logic [TW-1:0]       cmd_n_tiles,
  input  logic [TW-1:0]       cmd_k_tiles,
  output logic                a_rd_en,
  output logic [ADDRW-1:0]    a_rd_addr,
  input  logic [16*AW-1:0]    a_rd_data,
  output logic                b_rd_en,
  output logic [ADDRW-1:0]    b_rd_addr,
  input  logic [16*BW-1:0]    b_rd_data,
  output logic                arr_start,
  output logic [16*AW-1:0]    arr_a,
  output logic [16*BW-1:0]    arr_b,
  input  logic                arr_done,
  input  logic [16*ACCW-1:0]  arr_c,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [16*ACCW-1:0]  c_data,
  output logic [TW-1:0]       c_mi,
  output logic [TW-1:0]       c_ni,
  output logic                c_last,
  output logic                job_done,
  output logic                busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WDONE = 3'd4;
  localparam logic [2:0] S_ACCUM = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [TW-1:0] L_ONE = TW'(1);

  logic [2:0]          r_state;
  logic                r_rdy;
  logic [TW-1:0]       r_mt;
  logic [TW-1:0]       r_nt;
  logic [TW-1:0]       r_kt;
  logic [TW-1:0]       r_mi;
  logic [TW-1:0]       r_ni;
  logic [TW-1:0]       r_ki;
  logic [16*AW-1:0]    r_arr_a;
  logic [16*BW-1:0]    r_arr_b;
  logic [16*ACCW-1:0]  r_psum;

  logic w_last_k;
  logic w_last_n;
  logic w_last_m;
  logic w_zero_cmd;

  assign w_last_k   = (r_ki == r_kt - L_ONE);
  assign w_last_n   = (r_ni == r_nt - L_ONE);
  assign w_last_m   = (r_mi == r_mt - L_ONE);
  assign w_zero_cmd = (cmd_m_tiles == '0) || (cmd_n_tiles == '0) || (cmd_k_tiles == '0);

  // Addresses wrap modulo 2^ADDRW; the job is required to fit.
  assign a_rd_addr = ADDRW'(r_mi) * ADDRW'(r_kt) + ADDRW'(r_ki);
  assign b_rd_addr = ADDRW'(r_ki) * ADDRW'(r_nt) + ADDRW'(r_ni);

  assign cmd_ready = r_rdy && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign a_rd_en   = (r_state == S_FETCH);
  assign b_rd_en   = (r_state == S_FETCH);
  assign arr_start = (r_state == S_START);
  assign arr_a     = r_arr_a;
  assign arr_b     = r_arr_b;
  assign c_valid   = (r_state == S_OUT);
  assign c_data    = r_psum;
  assign c_mi      = r_mi;
  assign c_ni      = r_ni;
  assign c_last    = c_valid && w_last_m && w_last_n;
  assign job_done  = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
      r_mt    <= '0;
      r_nt    <= '0;
      r_kt    <= '0;
      r_mi    <= '0;
      r_ni    <= '0;
      r_ki    <= '0;
      r_arr_a <= '0;
      r_arr_b <= '0;
      r_psum  <= '0;
    end else begin
      r_rdy <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_rdy) begin
            r_mt    <= cmd_m_tiles;
            r_nt    <= cmd_n_tiles;
            r_kt    <= cmd_k_tiles;
            r_mi    <= '0;
            r_ni    <= '0;
            r_ki    <= '0;
            r_state <= w_zero_cmd ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: r_state <= S_WDATA;
        S_WDATA: begin
          r_arr_a <= a_rd_data;
          r_arr_b <= b_rd_data;
          r_state <= S_START;
        end
        S_START: r_state <= S_WDONE;
        S_WDONE: begin
          // Fold arr_c in on the done cycle so ACCUM only has to pick the next step.
          if (arr_done) begin
            for (int e = 0; e < 16; e++) begin
              r_psum[e*ACCW +: ACCW] <= (r_ki == '0) ? arr_c[e*ACCW +: ACCW]
                                        : r_psum[e*ACCW +: ACCW] + arr_c[e*ACCW +: ACCW];
            end
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_last_k) begin
            r_state <= S_OUT;
          end else begin
            r_ki    <= r_ki + L_ONE;
            r_state <= S_FETCH;
          end
        end
        S_OUT: begin
          if (c_ready) begin
            r_ki <= '0;
            if (w_last_m && w_last_n) begin
              r_state <= S_DONE;
            end else begin
              if (w_last_n) begin
                r_ni <= '0;
                r_mi <= r_mi + L_ONE;
              end else begin
                r_ni <= r_ni + L_ONE;
              end
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_tile_scheduler.md
Name: systolic_tile_scheduler

Overview:
- Sequences a 4x4 output-stationary systolic MAC array (ROWS=COLS=K=4) over a tiled GEMM: C[M_T×4, N_T×4] = A[M_T×4, K_T×4] · B[K_T×4, N_T×4].
- Fetches A/B tiles from two tile memories, pulses the array start, and accumulates per-tile results across the K dimension. Streams each finished C tile out on a valid/ready port.
- Sits between the command/DMA layer and the array instance.

Parameters:
- AW, 8, signed A element width.
- BW, 8, signed B element width.
- ACCW, 32, accumulator/C element width.
- TW, 8, width of tile-count fields.
- ADDRW, 16, tile memory address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE
- cmd_m_tiles  in  TW  M tile count
- cmd_n_tiles  in  TW  N tile count
- cmd_k_tiles  in  TW  K tile count
- a_rd_en  out  1  A tile read strobe
- a_rd_addr  out  ADDRW  A tile address = mi*k_tiles+ki
- a_rd_data  in  16*AW  A tile, valid exactly 1 cycle after a_rd_en; element (r,k) at bits [(r*4+k)*AW +: AW]
- b_rd_en  out  1  B tile read strobe
- b_rd_addr  out  ADDRW  B tile address = ki*n_tiles+ni
- b_rd_data  in  16*BW  B tile, 1-cycle latency; element (k,c) at bits [(k*4+c)*BW +: BW]
- arr_start  out  1  one-cycle start pulse to array
- arr_a  out  16*AW  registered A tile to array
- arr_b  out  16*BW  registered B tile to array
- arr_done  in  1  one-cycle array completion pulse
- arr_c  in  16*ACCW  array result, valid when arr_done=1
- c_valid  out  1  output tile valid
- c_ready  in  1  output tile accept
- c_data  out  16*ACCW  accumulated C tile, same packing as arr_c
- c_mi  out  TW  tile row index of c_data
- c_ni  out  TW  tile column index of c_data
- c_last  out  1  high with the final tile of the job
- job_done  out  1  one-cycle pulse at job completion
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; all counters, psum, arr_a, arr_b, c_data, c_mi and c_ni are 0.
  - arr_start, a_rd_en, b_rd_en, c_valid, c_last, job_done and busy are 0; cmd_ready=1 one cycle after reset deassertion.
- Command acceptance:
  - Accepted on cmd_valid&&cmd_ready; tile counts are latched.
  - If any count is 0: no reads and no outputs; job_done pulses the next cycle and the block returns to IDLE.
- Loop order: mi outer, ni middle, ki inner; all indices start at 0.
- States and transitions:
  - IDLE -> FETCH on acceptance.
  - FETCH (1 cycle): a_rd_en=b_rd_en=1 with current addresses.
  - WAIT_DATA (1 cycle): capture a_rd_data/b_rd_data into arr_a/arr_b.
  - START (1 cycle): arr_start=1. arr_a/arr_b are held stable until the next FETCH.
  - WAIT_DONE: hold until arr_done. arr_start and arr_done are ignored outside their states.
  - ACCUM (1 cycle):
    - ki==0: psum = arr_c.
    - ki>0: psum = psum + arr_c, element-wise signed, modulo 2^ACCW (wraps, no saturation).
    - arr_c is captured on the arr_done cycle.
    - If ki<k_tiles-1: ki++ -> FETCH. Otherwise -> OUT.
  - OUT: c_valid=1 with c_data=psum, c_mi=mi, c_ni=ni, c_last=(mi==m_tiles-1 && ni==n_tiles-1).
    - All outputs hold stable while c_valid && !c_ready.
    - On handshake: ki=0 and advance ni, then mi -> FETCH. If it was the last tile: job_done=1 in the next cycle and return to IDLE.
- Latency:
  - Per k-step: 3 + array cycles + 1. The reference array latency is 11 cycles start-to-done.
  - 1x1x1 job: first c_valid 16 cycles after acceptance.
- Address width: addresses are truncated to ADDRW; the job must fit in ADDRW.
- Reset mid-job: the job is aborted with no output. The array is reset by the same rst_n.
- cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- 1x1x1 job; A=identity, B element (k,c)=k*4+c+1 -> one c_valid; c_data equals B sign-extended; c_mi=c_ni=0; c_last=1; job_done one cycle after handshake.
- 1x1x2 job; A tiles all 2, B tiles all 3 -> reads at addrs 0,1 on both ports; every c element = 2·(4·2·3) = 48; exactly two arr_start pulses.
- 2x2x1 job with distinct tiles -> output order (0,0),(0,1),(1,0),(1,1); c_last only on (1,1); B addresses 0,1,0,1; A addresses 0,0,1,1.
- Backpressure: hold c_ready=0 for 5 cycles in OUT -> c_valid, c_data, c_mi and c_ni stable; no new a_rd_en until handshake.
- Wrap: A=127, B=127 tiles, k_tiles=2 with ACCW=16 -> element 4·16129·2 = 129032 mod 2^16 = -2040.
- Zero count (m_tiles=0) -> no rd_en, no c_valid, job_done pulse; rst_n asserted during WAIT_DONE -> all outputs 0 immediately, cmd_ready=1 after release.
